adder_err_sweeper: RTL and testbench

Sequential error-characterization controller for one approximate ripple-carry adder (the 8-bit RC family). It steps exhaustively through every operand pair, drives the pair into an external combinational adder under test, and compares the returned sum against an exact sum computed internally. It accumulates error count, sum of absolute error, signed bias, and the worst-case error with its first operand pair. It sits beside the adder instance in characterization builds and replaces off-line simulation sweeps for MAE/ER/WCE figures.

---
 rtl/adder_err_pkg.sv | 16 +
 rtl/adder_err_accum.sv | 78 +++++++
 rtl/adder_err_sweeper.sv | 118 +++++++++++
 tb/tb_adder_err_sweeper.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_err_pkg.sv
// Shared types and width rules for the approximate-adder error sweeper.
package adder_err_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int W_DEF = 8;
   localparam int CNT_W = 2 * W_DEF;
   localparam int ABS_W = 3 * W_DEF + 1;
   localparam int SGN_W = 3 * W_DEF + 2;

endpackage

// File: rtl/adder_err_accum.sv
// Stage 2 of the sweeper: signed error, magnitude, and the running statistics.
module adder_err_accum
   import adder_err_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int AW = ABS_W,
   parameter int SW = SGN_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_vld,
   input  logic [W:0]    i_sum_p1,
   input  logic [W:0]    i_exact_p1,
   input  logic [W-1:0]  i_a_p1,
   input  logic [W-1:0]  i_b_p1,
   output logic [2*W:0]  o_err_count,
   output logic [AW-1:0] o_sum_abs,
   output logic [SW-1:0] o_sum_sgn,
   output logic [W:0]    o_max_abs,
   output logic [W-1:0]  o_wce_a,
   output logic [W-1:0]  o_wce_b
);

   // |err| never exceeds 2^(W+1)-1, so W+1 bits always hold it.
   function automatic logic [W:0] abs_err(input logic signed [W+1:0] e);
      return (W+1)'(e[W+1] ? -e : e);
   endfunction

   logic signed [W+1:0] w_err;
   logic        [W:0]   w_abs;
   logic        [2*W:0] r_err_count;
   logic        [AW-1:0] r_sum_abs;
   logic signed [SW-1:0] r_sum_sgn;
   logic        [W:0]   r_max_abs;
   logic        [W-1:0] r_wce_a;
   logic        [W-1:0] r_wce_b;

   assign w_err = $signed({1'b0, i_sum_p1}) - $signed({1'b0, i_exact_p1});
   assign w_abs = abs_err(w_err);

   // ---- stage 2: accumulate ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
         r_sum_abs   <= '0;
         r_sum_sgn   <= '0;
         r_max_abs   <= '0;
         r_wce_a     <= '0;
         r_wce_b     <= '0;
      end else if (i_clr) begin
         r_err_count <= '0;
         r_sum_abs   <= '0;
         r_sum_sgn   <= '0;
         r_max_abs   <= '0;
         r_wce_a     <= '0;
         r_wce_b     <= '0;
      end else if (i_vld) begin
         r_err_count <= r_err_count + {{(2*W){1'b0}}, (w_err != '0)};
         r_sum_abs   <= r_sum_abs + AW'(w_abs);
         r_sum_sgn   <= r_sum_sgn + {{(SW-W-2){w_err[W+1]}}, w_err};
         // Strictly greater keeps the earliest pair on ties.
         if (w_abs > r_max_abs) begin
            r_max_abs <= w_abs;
            r_wce_a   <= i_a_p1;
            r_wce_b   <= i_b_p1;
         end
      end
   end

   assign o_err_count = r_err_count;
   assign o_sum_abs   = r_sum_abs;
   assign o_sum_sgn   = r_sum_sgn;
   assign o_max_abs   = r_max_abs;
   assign o_wce_a     = r_wce_a;
   assign o_wce_b     = r_wce_b;

endmodule

// File: rtl/adder_err_sweeper.sv
// Exhaustive operand sweep of an external W+W adder, comparing against the exact sum.
module adder_err_sweeper
   import adder_err_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   output logic [W-1:0]   op_a,
   output logic [W-1:0]   op_b,
   input  logic [W:0]     dut_sum,
   output logic           busy,
   output logic           done,
   output logic [2*W:0]   err_count,
   output logic [3*W:0]   sum_abs_err,
   output logic [3*W+1:0] sum_sgn_err,
   output logic [W:0]     max_abs_err,
   output logic [W-1:0]   wce_a,
   output logic [W-1:0]   wce_b
);

   localparam int L_CNT = (W == W_DEF) ? CNT_W : 2 * W;

   state_t           r_state;
   logic [L_CNT-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_vld_p1;
   logic [W:0]       r_sum_p1;
   logic [W:0]       r_exact_p1;
   logic [W-1:0]     r_a_p1;
   logic [W-1:0]     r_b_p1;
   logic             w_start_ok;
   logic             w_clr;

   assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
   assign w_clr      = abort || w_start_ok;

   // ---- control: FSM and sweep counter (A is the major index) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (abort) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == '1) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               r_state <= ST_DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign op_a = r_cnt[L_CNT-1:W];
   assign op_b = r_cnt[W-1:0];

   // ---- stage 1: capture returned sum and exact reference ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_vld_p1 <= 1'b0;
      else if (abort) r_vld_p1 <= 1'b0;
      else            r_vld_p1 <= (r_state == ST_RUN);
   end

   always_ff @(posedge clk) begin
      r_sum_p1   <= dut_sum;
      r_exact_p1 <= {1'b0, op_a} + {1'b0, op_b};
      r_a_p1     <= op_a;
      r_b_p1     <= op_b;
   end

   adder_err_accum #(
      .W  (W),
      .AW (3 * W + 1),
      .SW (3 * W + 2)
   ) u_accum (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clr       (w_clr),
      .i_vld       (r_vld_p1),
      .i_sum_p1    (r_sum_p1),
      .i_exact_p1  (r_exact_p1),
      .i_a_p1      (r_a_p1),
      .i_b_p1      (r_b_p1),
      .o_err_count (err_count),
      .o_sum_abs   (sum_abs_err),
      .o_sum_sgn   (sum_sgn_err),
      .o_max_abs   (max_abs_err),
      .o_wce_a     (wce_a),
      .o_wce_b     (wce_b)
   );

   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_adder_err_sweeper.sv
// Scoreboard bench: reduced-width sweeper against a plain-arithmetic statistics model.
module tb_adder_err_sweeper;

   localparam int TW    = 4;
   localparam int NP    = 1 << (2 * TW);
   localparam int SWEEP = NP + 1;

   typedef struct {
      int     cnt;
      longint sabs;
      longint ssgn;
      int     mx;
      int     wa;
      int     wb;
      longint dcyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [TW-1:0]   op_a, op_b;
   logic [TW:0]     dut_sum;
   logic            busy, done;
   logic [2*TW:0]   err_count;
   logic [3*TW:0]   sum_abs_err;
   logic [3*TW+1:0] sum_sgn_err;
   logic [TW:0]     max_abs_err;
   logic [TW-1:0]   wce_a, wce_b;

   int          mode = 0;
   logic [TW:0] tbl [0:NP-1];
   longint      cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic        prev_done = 1'b0;
   exp_t        sb[$];
   exp_t        last;

   adder_err_sweeper #(.W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .op_a(op_a), .op_b(op_b), .dut_sum(dut_sum),
      .busy(busy), .done(done), .err_count(err_count),
      .sum_abs_err(sum_abs_err), .sum_sgn_err(sum_sgn_err),
      .max_abs_err(max_abs_err), .wce_a(wce_a), .wce_b(wce_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Approximate adder under test, selected by mode.
   function automatic int adder_model(input int a, input int b);
      int s;
      s = a + b;
      case (mode)
         0: return s;
         1: return s & ~1;
         2: return s % (1 << TW);
         default: return s ^ int'(tbl[a * (1 << TW) + b]);
      endcase
   endfunction

   assign dut_sum = (TW+1)'(adder_model(int'(op_a), int'(op_b)));

   task automatic compute_exp(output exp_t e);
      int d, er, ab;
      e.cnt = 0; e.sabs = 0; e.ssgn = 0; e.mx = 0; e.wa = 0; e.wb = 0; e.dcyc = 0;
      for (int a = 0; a < (1 << TW); a++)
         for (int b = 0; b < (1 << TW); b++) begin
            d  = adder_model(a, b) & ((1 << (TW + 1)) - 1);
            er = d - (a + b);
            ab = (er < 0) ? -er : er;
            if (er != 0) e.cnt++;
            e.sabs += ab;
            e.ssgn += er;
            if (ab > e.mx) begin
               e.mx = ab; e.wa = a; e.wb = b;
            end
         end
   endtask

   task automatic randomize_tbl();
      for (int i = 0; i < NP; i++)
         tbl[i] = ($urandom_range(0, 3) == 0) ?
                  (TW+1)'($urandom_range(1, (1 << (TW + 1)) - 1)) : '0;
   endtask

   task automatic chk(input string nm, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic chk_res(input string tag, input exp_t e);
      logic signed [3*TW+1:0] s;
      s = sum_sgn_err;
      chk({tag, ".err_count"},   longint'(err_count),   longint'(e.cnt));
      chk({tag, ".sum_abs_err"}, longint'(sum_abs_err), e.sabs);
      chk({tag, ".sum_sgn_err"}, longint'(s),           e.ssgn);
      chk({tag, ".max_abs_err"}, longint'(max_abs_err), longint'(e.mx));
      chk({tag, ".wce_a"},       longint'(wce_a),       longint'(e.wa));
      chk({tag, ".wce_b"},       longint'(wce_b),       longint'(e.wb));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".busy"},        longint'(busy),        0);
      chk({tag, ".done"},        longint'(done),        0);
      chk({tag, ".op_a"},        longint'(op_a),        0);
      chk({tag, ".op_b"},        longint'(op_b),        0);
      chk({tag, ".err_count"},   longint'(err_count),   0);
      chk({tag, ".sum_abs_err"}, longint'(sum_abs_err), 0);
      chk({tag, ".sum_sgn_err"}, longint'(sum_sgn_err), 0);
      chk({tag, ".max_abs_err"}, longint'(max_abs_err), 0);
   endtask

   // Called at a negedge; returns at the negedge after the sampling edge E0.
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_expect();
      exp_t e;
      compute_exp(e);
      pulse_start();
      e.dcyc = cyc + SWEEP;
      sb.push_back(e);
      last = e;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < SWEEP + 20 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) chk({tag, ".done_timeout"}, 0, 1);
      else chk({tag, ".busy_at_done"}, longint'(busy), 0);
   endtask

   // Monitor: pops one expectation per rising done.
   always @(negedge clk) begin
      exp_t e;
      if (done && !prev_done) begin
         if (sb.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = sb.pop_front();
            chk_res("sweep", e);
            chk("sweep.done_cycle", cyc, e.dcyc);
         end
      end
      prev_done = done;
   end

   initial begin
      randomize_tbl();
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      mode = 0; run_expect();
      chk("busy_rise", longint'(busy), 1);
      wait_done("exact");
      mode = 1; run_expect(); wait_done("lsb_clear");
      mode = 2; run_expect(); wait_done("carry_drop");
      for (int r = 0; r < 3; r++) begin
         mode = 3; randomize_tbl();
         run_expect(); wait_done("random");
      end

      mode = 1; run_expect();
      repeat (100) @(negedge clk);
      pulse_start();
      wait_done("start_ignored");

      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i % 10 == 0) begin
            chk_res("hold", last);
            chk("hold.done", longint'(done), 1);
         end
      end

      run_expect();
      chk("restart.err_count", longint'(err_count), 0);
      chk("restart.max_abs_err", longint'(max_abs_err), 0);
      chk("restart.done", longint'(done), 0);
      chk("restart.busy", longint'(busy), 1);
      wait_done("restart");

      mode = 3; randomize_tbl();
      pulse_start();
      repeat (50) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_zero("abort");
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_over_start.busy", longint'(busy), 0);
      run_expect(); wait_done("after_abort");

      mode = 2;
      pulse_start();
      repeat (50) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset.busy", longint'(busy), 0);
      run_expect(); wait_done("after_reset");

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", longint'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got t=%0t, expected completion", $time);
      $fatal(1, "timeout");
   end

endmodule
